// File: rtl/lfsr_checker_pkg.sv
// Shared LFSR definitions for the payload generator and the receive-side checker.
// Holds the Galois tap-mask table, the next-state/popcount helpers and FSM states.
package lfsr_checker_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ACQUIRE   = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    // Maximal-length masks for a right-shifting Galois register.
    // Bit len-1 is always set, so the feedback bit lands in the MSB.
    function automatic logic [31:0] tap_mask(input int unsigned len);
        logic [31:0] m;
        case (len)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    // fb = s[0]; next full state = {fb, reg} with the taps folded in.
    function automatic logic [31:0] lfsr_next(
        input logic [31:0] s,
        input int unsigned len
    );
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ tap_mask(len);
        end
        return n;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Receive stream into the checker and its status/BER report back out.
// master: symbol source/observer; slave: the checker.
interface lfsr_checker_if #(
    parameter int unsigned SYM_W = 4
);
    logic             clk_en;
    logic [SYM_W-1:0] sym_in;
    logic             sync_in;
    logic             locked;
    logic             sym_err;
    logic             loss_of_lock;
    logic             window_done;
    logic [31:0]      bit_err_count;
    logic [31:0]      sym_count;
    logic [15:0]      resync_count;

    modport master (
        output clk_en, sym_in, sync_in,
        input  locked, sym_err, loss_of_lock, window_done,
        input  bit_err_count, sym_count, resync_count
    );

    modport slave (
        input  clk_en, sym_in, sync_in,
        output locked, sym_err, loss_of_lock, window_done,
        output bit_err_count, sym_count, resync_count
    );
endinterface

// File: rtl/lfsr_checker_step.sv
// Combinational LFSR advance plus symbol extract, shared with the generator.
// Ports: state in, nxt_state = lfsr_next(state), sym = state[SYM_W-1:0].
module lfsr_checker_step
    import lfsr_checker_pkg::*;
#(
    parameter int unsigned LFSR_LEN = 22,
    parameter int unsigned SYM_W    = 4
) (
    input  logic [LFSR_LEN-1:0] state,
    output logic [LFSR_LEN-1:0] nxt_state,
    output logic [SYM_W-1:0]    sym
);

    assign nxt_state = LFSR_LEN'(lfsr_next(32'(state), LFSR_LEN));
    assign sym       = state[SYM_W-1:0];

endmodule

// File: rtl/lfsr_checker.sv
// LFSR payload checker: replica aligned by sync, lock FSM and per-period BER counts.
// Ports: clk, reset (async active-low), rx (slave: symbol stream in, status out).
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int unsigned LFSR_LEN   = 22,
    parameter logic [31:0] LFSR_SEED  = 32'h0000_0001,
    parameter int unsigned SYM_W      = 4,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_ERR = 8
) (
    input logic           clk,
    input logic           reset,
    lfsr_checker_if.slave rx
);

    localparam logic [LFSR_LEN-1:0] SEED_ST = LFSR_SEED[LFSR_LEN-1:0];
    localparam logic [LFSR_LEN-1:0] RST_ST  =
        {1'b0, LFSR_SEED[LFSR_LEN-2:0]};
    localparam logic [15:0] LOCK_N   = 16'(LOCK_CNT);
    localparam logic [15:0] UNLOCK_N = 16'(UNLOCK_ERR);

    state_t              state, state_n;
    logic [LFSR_LEN-1:0] replica, replica_n;
    logic [15:0]         match_cnt, match_n;
    logic [15:0]         err_run, err_run_n;
    logic [31:0]         bit_acc, bit_acc_n;
    logic [31:0]         sym_acc, sym_acc_n;
    logic [31:0]         bit_cnt, bit_cnt_n;
    logic [31:0]         sym_cnt, sym_cnt_n;
    logic [15:0]         resync, resync_n;
    logic                sym_err, sym_err_n;
    logic                lol, lol_n;
    logic                wdone, wdone_n;

    logic [LFSR_LEN-1:0] cur;
    logic [LFSR_LEN-1:0] nxt;
    logic [SYM_W-1:0]    exp_sym;
    logic [SYM_W-1:0]    diff;
    logic                miss;
    logic [5:0]          nbits;

    // A sync symbol is checked against the seed, not the running replica.
    assign cur = rx.sync_in ? SEED_ST : replica;

    lfsr_checker_step #(
        .LFSR_LEN (LFSR_LEN),
        .SYM_W    (SYM_W)
    ) u_step (
        .state     (cur),
        .nxt_state (nxt),
        .sym       (exp_sym)
    );

    assign diff  = rx.sym_in ^ exp_sym;
    assign miss  = |diff;
    assign nbits = popcount(32'(diff));

    always_comb begin
        state_n   = state;
        replica_n = replica;
        match_n   = match_cnt;
        err_run_n = err_run;
        bit_acc_n = bit_acc;
        sym_acc_n = sym_acc;
        bit_cnt_n = bit_cnt;
        sym_cnt_n = sym_cnt;
        resync_n  = resync;
        sym_err_n = 1'b0;
        lol_n     = 1'b0;
        wdone_n   = 1'b0;
        if (rx.clk_en) begin
            unique case (state)
                WAIT_SYNC, ACQUIRE: begin
                    if (state == ACQUIRE || rx.sync_in) begin
                        replica_n = nxt;
                        if (miss) begin
                            state_n = WAIT_SYNC;
                            match_n = '0;
                        end else begin
                            if (rx.sync_in || state == WAIT_SYNC) begin
                                match_n = 16'd1;
                            end else begin
                                match_n = match_cnt + 16'd1;
                            end
                            if (match_n >= LOCK_N) begin
                                state_n   = LOCKED;
                                bit_acc_n = '0;
                                sym_acc_n = '0;
                                err_run_n = '0;
                            end else begin
                                state_n = ACQUIRE;
                            end
                        end
                    end
                end
                LOCKED: begin
                    replica_n = nxt;
                    sym_err_n = miss;
                    if (rx.sync_in && replica != SEED_ST && !(&resync)) begin
                        resync_n = resync + 16'd1;
                    end
                    sym_acc_n = sat_add(sym_acc, 32'd1);
                    bit_acc_n = sat_add(bit_acc, 32'(nbits));
                    // Replica is about to re-enter the seed: period closes here,
                    // current symbol included.
                    if (nxt == SEED_ST) begin
                        sym_cnt_n = sym_acc_n;
                        bit_cnt_n = bit_acc_n;
                        wdone_n   = 1'b1;
                        sym_acc_n = '0;
                        bit_acc_n = '0;
                    end
                    if (miss) begin
                        err_run_n = err_run + 16'd1;
                        if (err_run_n >= UNLOCK_N) begin
                            state_n   = WAIT_SYNC;
                            lol_n     = 1'b1;
                            match_n   = '0;
                            err_run_n = '0;
                        end
                    end else begin
                        err_run_n = '0;
                    end
                end
                default: begin
                    state_n = WAIT_SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= WAIT_SYNC;
            replica   <= RST_ST;
            match_cnt <= '0;
            err_run   <= '0;
            bit_acc   <= '0;
            sym_acc   <= '0;
            bit_cnt   <= '0;
            sym_cnt   <= '0;
            resync    <= '0;
            sym_err   <= 1'b0;
            lol       <= 1'b0;
            wdone     <= 1'b0;
        end else begin
            state     <= state_n;
            replica   <= replica_n;
            match_cnt <= match_n;
            err_run   <= err_run_n;
            bit_acc   <= bit_acc_n;
            sym_acc   <= sym_acc_n;
            bit_cnt   <= bit_cnt_n;
            sym_cnt   <= sym_cnt_n;
            resync    <= resync_n;
            sym_err   <= sym_err_n;
            lol       <= lol_n;
            wdone     <= wdone_n;
        end
    end

    assign rx.locked        = (state == LOCKED);
    assign rx.sym_err       = sym_err;
    assign rx.loss_of_lock  = lol;
    assign rx.window_done   = wdone;
    assign rx.bit_err_count = bit_cnt;
    assign rx.sym_count     = sym_cnt;
    assign rx.resync_count  = resync;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker with an 8-bit generator model (period 255).
// Covers reset, lock, windows, injected errors, slip/resync, unlock, acquire fail.
module tb_lfsr_checker;

    localparam int unsigned LEN   = 8;
    localparam logic [7:0]  SEED8 = 8'h5A;
    localparam logic [31:0] SEED  = {24'd0, SEED8};
    localparam int          PER   = 255;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lfsr_checker_if #(.SYM_W(4)) rx ();

    lfsr_checker #(
        .LFSR_LEN   (LEN),
        .LFSR_SEED  (SEED),
        .SYM_W      (4),
        .LOCK_CNT   (16),
        .UNLOCK_ERR (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx)
    );

    typedef struct {
        int         off;
        logic [3:0] flip;
        logic       exp_err;
    } vec_t;

    vec_t       vt [5];
    logic [7:0] gen;
    int         off;
    logic [3:0] flip_map [0:PER-1];
    int         n_cmp, n_bad;
    int         se_cnt, wd_cnt, lol_cnt, unl_cnt;

    function automatic logic [7:0] gen_step(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // One generator symbol; en=0 hides it from the checker (slip).
    task automatic send(input logic en);
        rx.clk_en  = en;
        rx.sym_in  = gen[3:0] ^ flip_map[off];
        rx.sync_in = en && (gen == SEED8);
        @(posedge clk);
        #1;
        if (rx.sym_err) se_cnt++;
        if (rx.window_done) wd_cnt++;
        if (rx.loss_of_lock) lol_cnt++;
        if (!rx.locked) unl_cnt++;
        gen = gen_step(gen);
        off = (off == PER - 1) ? 0 : off + 1;
        @(negedge clk);
        rx.clk_en  = 1'b0;
        rx.sync_in = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (off != target) send(1'b1);
    endtask

    task automatic run_period();
        send(1'b1);
        run_to(0);
    endtask

    task automatic clear_flips();
        for (int i = 0; i < PER; i++) flip_map[i] = 4'h0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        se_cnt = 0; wd_cnt = 0; lol_cnt = 0; unl_cnt = 0;
        clear_flips();
        vt[0] = '{10, 4'h1, 1'b1};
        vt[1] = '{20, 4'h1, 1'b1};
        vt[2] = '{30, 4'h1, 1'b1};
        vt[3] = '{40, 4'hF, 1'b1};
        vt[4] = '{50, 4'h0, 1'b0};
        gen = SEED8; off = 0;
        rx.clk_en = 1'b0; rx.sym_in = 4'h0; rx.sync_in = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_locked", 32'(rx.locked), 0);
        chk("rst_sym_err", 32'(rx.sym_err), 0);
        chk("rst_lol", 32'(rx.loss_of_lock), 0);
        chk("rst_wdone", 32'(rx.window_done), 0);
        chk("rst_bits", rx.bit_err_count, 0);
        chk("rst_syms", rx.sym_count, 0);
        chk("rst_resync", 32'(rx.resync_count), 0);
        reset = 1'b1;
        @(negedge clk);

        // Lock: sync symbol counts as the first match.
        for (int i = 0; i < 16; i++) begin
            send(1'b1);
            chk($sformatf("lock_%0d", i), 32'(rx.locked), 32'(i == 15));
        end
        chk("lock_no_sym_err", se_cnt, 0);
        wd_cnt = 0;
        run_to(0);
        chk("win1_done", wd_cnt, 1);
        chk("win1_syms", rx.sym_count, PER - 16);
        chk("win1_bits", rx.bit_err_count, 0);

        wd_cnt = 0;
        run_period();
        chk("win2_done", wd_cnt, 1);
        chk("win2_done_last", 32'(rx.window_done), 1);
        chk("win2_syms", rx.sym_count, PER);
        chk("win2_bits", rx.bit_err_count, 0);
        chk("win2_resync", 32'(rx.resync_count), 0);

        // Injected errors: 3 single-bit flips, one 4-bit flip.
        se_cnt = 0; wd_cnt = 0; unl_cnt = 0;
        foreach (vt[k]) flip_map[vt[k].off] = vt[k].flip;
        foreach (vt[k]) begin
            run_to(vt[k].off);
            send(1'b1);
            chk($sformatf("inj_err_%0d", k), 32'(rx.sym_err),
                32'(vt[k].exp_err));
        end
        run_to(0);
        clear_flips();
        chk("inj_pulses", se_cnt, 4);
        chk("inj_bits", rx.bit_err_count, 7);
        chk("inj_syms", rx.sym_count, PER);
        chk("inj_done", wd_cnt, 1);
        chk("inj_stay_locked", unl_cnt, 0);

        // Slip one symbol just before the seed, then resync.
        lol_cnt = 0; unl_cnt = 0;
        run_to(251);
        send(1'b0);
        repeat (3) send(1'b1);
        send(1'b1);
        chk("slip_resync", 32'(rx.resync_count), 1);
        chk("slip_locked", 32'(rx.locked), 1);
        chk("slip_no_lol", lol_cnt, 0);
        wd_cnt = 0;
        run_to(0);
        chk("slip_win_done", wd_cnt, 1);
        chk("slip_win_syms", rx.sym_count, 509);
        wd_cnt = 0;
        run_period();
        chk("post_slip_syms", rx.sym_count, PER);
        chk("post_slip_bits", rx.bit_err_count, 0);
        chk("post_slip_resync", 32'(rx.resync_count), 1);
        chk("post_slip_locked_all", unl_cnt, 0);

        // Loss of lock on the 8th consecutive errored symbol.
        wd_cnt = 0;
        for (int i = 100; i < 108; i++) flip_map[i] = 4'hF;
        run_to(100);
        for (int k = 0; k < 8; k++) begin
            send(1'b1);
            chk($sformatf("lol_%0d", k), 32'(rx.loss_of_lock),
                32'(k == 7));
            chk($sformatf("lol_err_%0d", k), 32'(rx.sym_err), 1);
        end
        chk("lol_unlocked", 32'(rx.locked), 0);
        send(1'b1);
        chk("lol_one_shot", 32'(rx.loss_of_lock), 0);
        chk("lol_no_err_unlocked", 32'(rx.sym_err), 0);
        clear_flips();
        run_to(0);
        chk("lol_no_window", wd_cnt, 0);
        for (int i = 0; i < 16; i++) begin
            send(1'b1);
            chk($sformatf("relock_%0d", i), 32'(rx.locked),
                32'(i == 15));
        end

        // Asynchronous reset while locked.
        repeat (5) send(1'b1);
        chk("pre_rst_resync", 32'(rx.resync_count), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_locked", 32'(rx.locked), 0);
        chk("arst_syms", rx.sym_count, 0);
        chk("arst_bits", rx.bit_err_count, 0);
        chk("arst_resync", 32'(rx.resync_count), 0);
        chk("arst_wdone", 32'(rx.window_done), 0);
        gen = SEED8; off = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Acquire failure on the 5th symbol after sync.
        flip_map[4] = 4'hF;
        run_to(4);
        send(1'b1);
        chk("acq_fail_no_err", 32'(rx.sym_err), 0);
        chk("acq_fail_unlocked", 32'(rx.locked), 0);
        run_to(16);
        chk("acq_fail_still_unlocked", 32'(rx.locked), 0);
        clear_flips();
        run_to(0);
        for (int i = 0; i < 16; i++) send(1'b1);
        chk("acq_relock", 32'(rx.locked), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side counterpart of the maximal-length LFSR payload generator.
- Runs a local replica of the generator's LFSR, aligned by a sync marker, and compares each received symbol against the expected symbol.
- Reports lock state, per-symbol errors, and per-sequence-period bit/symbol error counts for BER measurement at the demodulator output.

Parameters:
- LFSR_LEN, `LFSR_LEN (22): replica register length in bits; valid range 3..32.
- LFSR_SEED, `LFSR_SEED: replica load value on sync; same seed as the generator.
- SYM_W, 4: received symbol width; symbol = replica state bits [SYM_W-1:0].
- LOCK_CNT, 16: consecutive matching symbols required to declare lock.
- UNLOCK_ERR, 8: consecutive errored symbols that cause loss of lock.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clk_en  in  1  symbol strobe; one received symbol per asserted cycle
- sym_in  in  SYM_W  received hard-decision symbol, sampled when clk_en=1
- sync_in  in  1  with clk_en, marks that sym_in is the symbol emitted from generator state == LFSR_SEED
- locked  out  1  checker is in LOCKED
- sym_err  out  1  one-cycle pulse: the last checked symbol mismatched
- loss_of_lock  out  1  one-cycle pulse on the LOCKED -> WAIT_SYNC transition
- window_done  out  1  one-cycle pulse: the count outputs were just updated
- bit_err_count  out  32  bit errors in the last completed period, saturating
- sym_count  out  32  symbols checked in the last completed period, saturating
- resync_count  out  16  number of sync_in events seen while LOCKED with replica != SEED, saturating

Behaviour:
- Reset (reset=0): all outputs 0, state WAIT_SYNC, replica = {1'b0, SEED[LEN-2:0]}, accumulators 0.
- Replica next-state: identical to the generator.
  - Galois shift with feedback bit fb; tap mask from the shared table indexed by LFSR_LEN.
  - Full state = {fb, reg}.
  - Advances only on clk_en.
- Expected symbol = replica[SYM_W-1:0] before the advance.
  - When sync_in=1, use SEED-derived state instead, and replica becomes step(SEED state).
- Compare: mismatch = |(sym_in ^ expected); bit errors = popcount(sym_in ^ expected), range 0..SYM_W.
- All outputs are registered; they reflect a clk_en cycle on the following clk edge. Latency is 1 clk.
- No clk_en: all state holds and pulses deassert.
- FSM states and transitions:
  - WAIT_SYNC:
    - Ignore sym_in.
    - On clk_en&sync_in: load replica, run the compare, go to ACQUIRE with match_cnt = 1 on match, else stay in WAIT_SYNC.
  - ACQUIRE:
    - Each match increments match_cnt; at match_cnt == LOCK_CNT go to LOCKED and clear accumulators.
    - Any mismatch returns to WAIT_SYNC.
    - sync_in reloads the replica and restarts match_cnt at 1 (or 0 on mismatch).
  - LOCKED:
    - Each checked symbol increments sym_acc and adds its bit errors to bit_acc, both saturating at all-ones.
    - sym_err pulses on each mismatch.
    - err_run counts consecutive mismatches and clears on a match; at err_run == UNLOCK_ERR pulse loss_of_lock, drop locked, go to WAIT_SYNC.
    - sync_in with the current replica != SEED full state: increment resync_count, reload replica, stay LOCKED.
    - sync_in with the replica already at SEED: no count, no change.
- Window (LOCKED only):
  - When the replica advances to the SEED full state, latch bit_acc/sym_acc (including the current symbol) into the outputs.
  - Pulse window_done and clear the accumulators the same cycle.
  - Simultaneous wrap and loss of lock: the latch and window_done still occur, then unlock.
- sym_err is not asserted outside LOCKED.
- Reset mid-operation returns to the reset values immediately (asynchronous).

Decomposition:
- Shared package/header lfsr_pkg:
  - tap-mask table per length (moved from the generator so both ends share it)
  - lfsr_next(state, len) function
  - popcount function
  - FSM state encodings
- One natural sub-module: lfsr_step, the combinational next-state plus symbol extract, instantiated here and refactorable into the generator.

Test Plan:
- Error-free lock: generator → checker directly, sync on the generator's seed cycle → locked=1 exactly 16 clk_en after sync, sym_err never 1.
- Window count (LFSR_LEN=8 override, period 255): error-free → window_done every 255 symbols, sym_count=255, bit_err_count=0.
- Injected errors: flip bit 0 of 3 symbols and all 4 bits of 1 symbol in one period → bit_err_count=7, sym_err pulsed 4 times, locked stays 1.
- Loss of lock: force 8 consecutive corrupted symbols → loss_of_lock pulse on the 8th, locked=0, re-lock 16 symbols after the next sync_in.
- Slip/resync: drop one clk_en to the checker mid-period, then sync_in → resync_count=1, locked=1 after the reload, next window clean.
- Acquire failure and reset: mismatch at acquire symbol 5 → back to WAIT_SYNC, locked=0. Assert reset mid-LOCKED → all outputs 0 immediately.
